// File: rtl/bc_timing_sequencer.sv
// bc_timing_sequencer: S/SC/IEN/R control flip-flops and E-control decode for the basic computer, rev 1.0.
// Optional SEQ_WATCHDOG_EN: an SC overflow halts the machine and raises a sticky seq_err.
`default_nettype none

module bc_timing_sequencer #(
  parameter int SC_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     hlt,
  input  logic                     sc_clr,
  input  logic                     ien_set,
  input  logic                     ien_clr,
  input  logic                     fgi,
  input  logic                     fgo,
  input  logic [2:0]               e_op,
  input  logic                     ac_lsb,
  input  logic                     ac_msb,
  input  logic                     carry,
  input  logic                     e_outdata,
  output logic [2**SC_WIDTH-1:0]   t,
  output logic                     s_out,
  output logic                     ien_out,
  output logic                     r_out,
  output logic                     ff_en,
  output logic                     e_clr,
  output logic                     e_indata,
  output logic                     seq_err
);

  localparam logic [SC_WIDTH-1:0] c_SC_T2  = SC_WIDTH'(2);
  localparam logic [SC_WIDTH-1:0] c_SC_ONE = SC_WIDTH'(1);

  logic                r_s;
  logic [SC_WIDTH-1:0] r_sc;
  logic                r_ien;
  logic                r_r;

  logic w_int_t2;
  logic w_r_set;
  logic w_wd_trip;

  // Interrupt cycle ends on its T2; R is only raised once T0..T2 are past.
  assign w_int_t2 = r_s & r_r & (r_sc == c_SC_T2);
  assign w_r_set  = r_s & ~r_r & r_ien & (fgi | fgo) & (r_sc > c_SC_T2);

`ifdef SEQ_WATCHDOG_EN
  logic r_err;

  assign w_wd_trip = r_s & ~hlt & ~sc_clr & ~w_int_t2 & (r_sc == {SC_WIDTH{1'b1}});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_wd_trip) begin
      r_err <= 1'b1;
    end
  end

  assign seq_err = r_err;
`else
  assign w_wd_trip = 1'b0;
  assign seq_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s   <= 1'b0;
      r_sc  <= '0;
      r_ien <= 1'b0;
      r_r   <= 1'b0;
    end else if (!r_s) begin
      if (start) begin
        r_s  <= 1'b1;
        r_sc <= '0;
      end
    end else begin
      if (w_int_t2) begin
        r_r   <= 1'b0;
        r_ien <= 1'b0;
      end else begin
        if (w_r_set) begin
          r_r <= 1'b1;
        end
        if (ien_clr) begin
          r_ien <= 1'b0;
        end else if (ien_set) begin
          r_ien <= 1'b1;
        end
      end

      if (hlt) begin
        r_s  <= 1'b0;
        r_sc <= '0;
      end else if (w_int_t2 || sc_clr) begin
        r_sc <= '0;
      end else if (w_wd_trip) begin
        r_s  <= 1'b0;
        r_sc <= '0;
      end else begin
        r_sc <= r_sc + c_SC_ONE;
      end
    end
  end

  always_comb begin
    t = '0;
    if (r_s) begin
      t[r_sc] = 1'b1;
    end
  end

  always_comb begin
    ff_en    = 1'b0;
    e_clr    = 1'b0;
    e_indata = 1'b0;
    if (r_s) begin
      case (e_op)
        3'd1: begin
          ff_en = 1'b1;
          e_clr = 1'b1;
        end
        3'd2: begin
          ff_en    = 1'b1;
          e_indata = ~e_outdata;
        end
        3'd3: begin
          ff_en    = 1'b1;
          e_indata = ac_lsb;
        end
        3'd4: begin
          ff_en    = 1'b1;
          e_indata = ac_msb;
        end
        3'd5: begin
          ff_en    = 1'b1;
          e_indata = carry;
        end
        default: begin
          ff_en = 1'b0;
        end
      endcase
    end
  end

  assign s_out   = r_s;
  assign ien_out = r_ien;
  assign r_out   = r_r;

endmodule

`default_nettype wire

// File: doc/bc_timing_sequencer.md
Name: bc_timing_sequencer

Overview:
- Timing and control-flip-flop sequencer for the basic computer.
- Runs the start/stop flip-flop S, the sequence counter SC with one-hot timing outputs T, the interrupt-enable flip-flop IEN and the interrupt-cycle flip-flop R.
- Generates the control inputs (ff_en, e_clr, e_indata) for the E flip-flop, from the register-reference/ADD operation requested by the control decoder.
- Sits between the instruction decoder and the register/flip-flop datapath.

Parameters:
- SC_WIDTH, 4, width of sequence counter; t output width is 2**SC_WIDTH.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level; sets S on next edge when S=0.
- hlt  input  1  HLT executed; clears S and SC on next edge.
- sc_clr  input  1  end-of-instruction; SC to 0 on next edge.
- ien_set  input  1  ION instruction.
- ien_clr  input  1  IOF instruction.
- fgi  input  1  input flag.
- fgo  input  1  output flag.
- e_op  input  3  E operation: 0 NOP, 1 CLE, 2 CME, 3 CIR, 4 CIL, 5 ADD carry, 6-7 NOP.
- ac_lsb  input  1  AC[0], for CIR.
- ac_msb  input  1  AC[15], for CIL.
- carry  input  1  adder carry-out, for ADD.
- e_outdata  input  1  current E flip-flop value.
- t  output  2**SC_WIDTH  one-hot timing signals T0..Tn.
- s_out  output  1  S flip-flop.
- ien_out  output  1  IEN flip-flop.
- r_out  output  1  R flip-flop; 1 = interrupt cycle.
- ff_en  output  1  E flip-flop load enable.
- e_clr  output  1  E flip-flop clear.
- e_indata  output  1  E flip-flop data.
- seq_err  output  1  sticky sequence error (optional feature only).

Behaviour:
- Reset (reset=0, asynchronous):
  - S=0, SC=0, IEN=0, R=0, seq_err=0.
  - t=0; ff_en, e_clr and e_indata all 0.
- t output:
  - t = one-hot(SC) when S=1; all zeros when S=0.
  - Registered state, combinational decode.
- S flip-flop:
  - S=0 and start=1: S←1, SC←0. T0 is visible the cycle after the edge.
  - S=1 and hlt=1: S←0, SC←0. hlt has priority over start.
- SC, only while S=1. Priority per edge:
  1. hlt clears SC.
  2. Interrupt-cycle T2 clears SC.
  3. sc_clr clears SC.
  4. Otherwise SC←SC+1, wrapping 2**SC_WIDTH-1 → 0 (absent the optional feature).
- R set:
  - Condition: S=1, R=0, IEN=1, (fgi|fgo)=1, and T0, T1, T2 all inactive (SC>2).
  - R←1 at that edge; SC is unaffected by this condition.
- Interrupt cycle (R=1):
  - Decoder runs the interrupt micro-ops on T0..T2.
  - At the T2 edge: R←0, IEN←0, SC←0 unconditionally, regardless of sc_clr.
- IEN:
  - ien_clr beats ien_set.
  - Interrupt-cycle T2 clear beats both.
  - IEN updates only while S=1.
- E control (combinational, all outputs 0 when S=0):
  - CLE: ff_en=1, e_clr=1, e_indata=0.
  - CME: ff_en=1, e_clr=0, e_indata=~e_outdata.
  - CIR: ff_en=1, e_indata=ac_lsb.
  - CIL: ff_en=1, e_indata=ac_msb.
  - ADD: ff_en=1, e_indata=carry.
  - NOP codes: ff_en=0, e_clr=0, e_indata=0.
  - Timing: E changes at the edge ending the cycle in which e_op is presented.
- Reset mid-instruction: all state is lost immediately; t drops to 0 within the same cycle, no clock needed.

Optional Feature:
- Macro: SEQ_WATCHDOG_EN.
- Defined: if SC=2**SC_WIDTH-1 and neither sc_clr nor the interrupt-T2 clear is active, then at that edge:
  - SC←0.
  - S←0 (machine halts).
  - seq_err←1, sticky until reset.
- Not defined:
  - SC wraps silently and S is unaffected.
  - seq_err is tied to 0.

Test Plan:
- Start: reset released, start=1 for one cycle → s_out=1; t=16'h0001, 16'h0002, 16'h0004 on consecutive cycles; sc_clr at T3 → t=16'h0001 next cycle.
- Halt: hlt=1 during T5 (start=1 also held) → next cycle s_out=0, t=0; start pulse afterwards → T0 again.
- Interrupt: ien_set during T3 → ien_out=1; fgi=1 at T4 → r_out=1 next edge; after sc_clr, T0,T1,T2 → after T2 edge r_out=0, ien_out=0, t=16'h0001.
- Interrupt inhibit: fgo=1, IEN=1, asserted only during T0–T2 → r_out stays 0; ien_set+ien_clr together → ien_out=0.
- E control, with e_outdata=1:
  - e_op=2 → ff_en=1, e_indata=0.
  - e_op=1 → e_clr=1.
  - e_op=3, ac_lsb=1 → e_indata=1.
  - e_op=5, carry=0 → e_indata=0.
  - e_op=7 → ff_en=0.
  - s_out=0 → all E outputs 0.
- Async reset: assert reset=0 at T7 between edges → t=0, s_out=0, r_out=0 immediately.
- Wrap: no sc_clr for 16 cycles:
  - SEQ_WATCHDOG_EN defined → seq_err=1, s_out=0.
  - Undefined → t returns to 16'h0001, seq_err=0.
